// File: rtl/servo_pwm_multi_if.sv
// Position-write port of the multi-channel servo PWM generator.
//   pos_valid  master -> slave  write request
//   pos_ready  slave -> master  write accepted when valid && ready
//   pos_ch     master -> slave  channel index
//   pos_data   master -> slave  target position (clamped by the slave)
//   pos_err    slave -> master  1-cycle pulse after a write to a nonexistent channel
interface servo_pwm_multi_if #(
  parameter int NUM_CH = 4,
  parameter int POS_W  = 16
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             pos_valid;
  logic             pos_ready;
  logic [CHW-1:0]   pos_ch;
  logic [POS_W-1:0] pos_data;
  logic             pos_err;

  modport master (
    output pos_valid, pos_ch, pos_data,
    input  pos_ready, pos_err
  );

  modport slave (
    input  pos_valid, pos_ch, pos_data,
    output pos_ready, pos_err
  );
endinterface

// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator. All channels share a single
// frame counter. Each channel has a host-written target position and a
// per-frame slew limiter. Position and enable only change on the last
// cycle of a frame, so every pulse within a frame has one exact width.
//   clk         system clock
//   rst_n       synchronous active-low reset
//   wr          position write port (slave side)
//   ch_enable   per-channel output enable, latched at frame boundary
//   servo_out   registered PWM outputs
//   at_target   current position equals target position
//   frame_tick  high on the last cycle of each frame
module servo_pwm_multi #(
  parameter int NUM_CH      = 4,
  parameter int PERIOD_CLKS = 500000,
  parameter int MIN_CLKS    = 25000,
  parameter int MAX_CLKS    = 50000,
  parameter int POS_W       = 16,
  parameter int SLEW_STEP   = 1000,
  parameter int INIT_POS    = 12500
) (
  input  logic              clk,
  input  logic              rst_n,
  servo_pwm_multi_if.slave  wr,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic [NUM_CH-1:0] servo_out,
  output logic [NUM_CH-1:0] at_target,
  output logic              frame_tick
);

  localparam int CW    = $clog2(PERIOD_CLKS);
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RANGE = MAX_CLKS - MIN_CLKS;

  localparam logic [POS_W-1:0] RANGE_P = POS_W'(RANGE);
  localparam logic [POS_W-1:0] INIT_P  = POS_W'(INIT_POS);
  // Only applied when the step is smaller than the distance to target,
  // which is at most RANGE, so the truncation here never matters.
  localparam logic [POS_W-1:0] SLEW_P  = POS_W'(SLEW_STEP);
  localparam logic [31:0]      SLEW_U  = 32'(SLEW_STEP);
  localparam logic [CW-1:0]    LAST_C  = CW'(PERIOD_CLKS - 1);
  localparam logic [CW-1:0]    MIN_C   = CW'(MIN_CLKS);

  if (MAX_CLKS >= PERIOD_CLKS) begin : g_chk_period
    $error("servo_pwm_multi: MAX_CLKS must be below PERIOD_CLKS");
  end
  if (MIN_CLKS > MAX_CLKS) begin : g_chk_min
    $error("servo_pwm_multi: MIN_CLKS must not exceed MAX_CLKS");
  end
  if (POS_W < 31 && RANGE >= (1 << POS_W)) begin : g_chk_range
    $error("servo_pwm_multi: RANGE does not fit in POS_W bits");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_chk_ch
    $error("servo_pwm_multi: NUM_CH must be 1..16");
  end

  logic [CW-1:0]    cnt;
  logic             accept;
  logic [POS_W-1:0] wdata;

  assign frame_tick = (cnt == LAST_C);
  assign accept     = wr.pos_valid && wr.pos_ready;
  // Out-of-range targets saturate at full scale instead of wrapping.
  assign wdata      = (wr.pos_data > RANGE_P) ? RANGE_P : wr.pos_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      wr.pos_ready <= 1'b0;
      wr.pos_err   <= 1'b0;
    end else begin
      cnt          <= frame_tick ? '0 : cnt + 1'b1;
      wr.pos_ready <= 1'b1;
      wr.pos_err   <= accept && (32'(wr.pos_ch) >= 32'(NUM_CH));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [POS_W-1:0] tgt;
    logic [POS_W-1:0] cur;
    logic [POS_W-1:0] cur_nxt;
    logic [POS_W:0]   diff;
    logic [POS_W:0]   mag;
    logic [CW-1:0]    width;
    logic             en_q;
    logic             out_q;

    // One extra bit so the sign of tgt-cur survives the subtraction.
    assign diff  = {1'b0, tgt} - {1'b0, cur};
    assign mag   = diff[POS_W] ? (~diff + 1'b1) : diff;
    assign width = MIN_C + CW'(cur);

    always_comb begin
      cur_nxt = tgt;
      if (SLEW_STEP != 0 && 32'(mag) > SLEW_U) begin
        cur_nxt = diff[POS_W] ? (cur - SLEW_P) : (cur + SLEW_P);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        tgt   <= INIT_P;
        cur   <= INIT_P;
        en_q  <= 1'b0;
        out_q <= 1'b0;
      end else begin
        // Compare against the pre-increment count: the pin rises one clk
        // after count 0 and stays high for exactly width clks.
        out_q <= en_q && (cnt < width);
        if (frame_tick) begin
          cur  <= cur_nxt;
          en_q <= ch_enable[g];
        end
        // A write in the update cycle lands after cur_nxt was taken,
        // so it is only seen at the following frame boundary.
        if (accept && (wr.pos_ch == CHW'(g))) begin
          tgt <= wdata;
        end
      end
    end

    assign servo_out[g] = out_q;
    assign at_target[g] = (cur == tgt);
  end

endmodule
